// File: rtl/vjtag_reg_bank.sv
// ---------------------------------------------------------------------------
// vjtag_reg_bank
//
// Data-register engine for a virtual-JTAG instance. Everything runs on tck.
// The virtual IR selects one of NUM_REGS data registers, or the 1-bit BYPASS
// register for any other code. A selected register is loaded from rd_data on
// Capture-DR, shifted LSB first on Shift-DR, and written back with a single
// wr_stb pulse on Update-DR, but only when exactly DR_WIDTH bits were shifted.
// A wrong-length shift sets the sticky shift_err flag instead. shift_err is
// reported through ir_out on Capture-IR and cleared there.
//
// Ports
//   tck                 vJTAG clock, rising edge
//   reset_n             synchronous active-low reset
//   tdi / tdo           serial data in / out (tdo is combinational)
//   ir_in / ir_out      virtual IR value in / status word out
//   virtual_state_*     one-hot TAP state indications from the vJTAG primitive
//   rd_data             parallel capture words, register k at [k*DR_WIDTH +: DR_WIDTH]
//   wr_data / wr_addr   shifted-in word and register index, valid with wr_stb
//   wr_stb              one-tck write strobe
//   shift_err           sticky: last Update-DR was discarded
// ---------------------------------------------------------------------------
module vjtag_reg_bank #(
    parameter int IR_WIDTH = 2,
    parameter int DR_WIDTH = 32,
    parameter int NUM_REGS = 3
) (
    input  logic                         tck,
    input  logic                         reset_n,
    input  logic                         tdi,
    output logic                         tdo,
    input  logic [IR_WIDTH-1:0]          ir_in,
    output logic [IR_WIDTH-1:0]          ir_out,
    input  logic                         virtual_state_cdr,
    input  logic                         virtual_state_sdr,
    input  logic                         virtual_state_e1dr,
    input  logic                         virtual_state_pdr,
    input  logic                         virtual_state_e2dr,
    input  logic                         virtual_state_udr,
    input  logic                         virtual_state_cir,
    input  logic                         virtual_state_uir,
    input  logic [NUM_REGS*DR_WIDTH-1:0] rd_data,
    output logic [DR_WIDTH-1:0]          wr_data,
    output logic [IR_WIDTH-1:0]          wr_addr,
    output logic                         wr_stb,
    output logic                         shift_err
);

    // Counter must hold DR_WIDTH+1 so that "one too many" is distinguishable
    // from "exact" and the counter never wraps back to a valid length.
    localparam int                   CNT_W        = $clog2(DR_WIDTH + 2);
    localparam logic [CNT_W-1:0]     CNT_FULL     = CNT_W'(DR_WIDTH);
    localparam logic [CNT_W-1:0]     CNT_SAT      = CNT_W'(DR_WIDTH + 1);
    localparam logic [IR_WIDTH-1:0]  INSTR_BYPASS = '1;
    localparam logic [IR_WIDTH-1:0]  NUM_REGS_IR  = IR_WIDTH'(NUM_REGS);

    logic [IR_WIDTH-1:0] instr_q,     instr_d;
    logic [DR_WIDTH-1:0] shift_reg_q, shift_reg_d;
    logic                bypass_q,    bypass_d;
    logic [CNT_W-1:0]    shift_cnt_q, shift_cnt_d;
    logic [DR_WIDTH-1:0] wr_data_q,   wr_data_d;
    logic [IR_WIDTH-1:0] wr_addr_q,   wr_addr_d;
    logic                wr_stb_q,    wr_stb_d;
    logic                shift_err_q, shift_err_d;
    logic [IR_WIDTH-1:0] ir_out_q,    ir_out_d;

    logic                sel_valid;
    logic [DR_WIDTH-1:0] cap_word;

    // Exit1/Pause/Exit2 only require every register to hold, which the
    // defaults below already give; these inputs carry no extra information.
    logic unused_hold_states;
    assign unused_hold_states = virtual_state_e1dr ^ virtual_state_pdr ^ virtual_state_e2dr;

    assign sel_valid = (instr_q < NUM_REGS_IR);

    // Capture mux: codes outside 0..NUM_REGS-1 leave cap_word at zero, but it
    // is only consumed when sel_valid is set.
    always_comb begin
        cap_word = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (instr_q == IR_WIDTH'(k)) begin
                cap_word = rd_data[k*DR_WIDTH +: DR_WIDTH];
            end
        end
    end

    always_comb begin
        instr_d     = instr_q;
        shift_reg_d = shift_reg_q;
        bypass_d    = bypass_q;
        shift_cnt_d = shift_cnt_q;
        wr_data_d   = wr_data_q;
        wr_addr_d   = wr_addr_q;
        wr_stb_d    = 1'b0;
        shift_err_d = shift_err_q;
        ir_out_d    = ir_out_q;

        // Capture-IR is independent of the DR path. It is evaluated first so
        // that a simultaneous Update-DR error below overrides the clear.
        if (virtual_state_cir) begin
            ir_out_d    = '0;
            ir_out_d[0] = shift_err_q;
            shift_err_d = 1'b0;
        end

        if (virtual_state_uir) begin
            instr_d = ir_in;
        end else if (virtual_state_cdr) begin
            shift_cnt_d = '0;
            if (sel_valid) begin
                shift_reg_d = cap_word;
            end else begin
                bypass_d = 1'b0;
            end
        end else if (virtual_state_sdr) begin
            if (sel_valid) begin
                shift_reg_d = {tdi, shift_reg_q[DR_WIDTH-1:1]};
            end else begin
                bypass_d = tdi;
            end
            if (shift_cnt_q != CNT_SAT) begin
                shift_cnt_d = shift_cnt_q + CNT_W'(1);
            end
        end else if (virtual_state_udr && sel_valid) begin
            if (shift_cnt_q == CNT_FULL) begin
                wr_stb_d  = 1'b1;
                wr_data_d = shift_reg_q;
                wr_addr_d = instr_q;
            end else begin
                shift_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge tck) begin
        if (!reset_n) begin
            instr_q     <= INSTR_BYPASS;
            shift_reg_q <= '0;
            bypass_q    <= 1'b0;
            shift_cnt_q <= '0;
            wr_data_q   <= '0;
            wr_addr_q   <= '0;
            wr_stb_q    <= 1'b0;
            shift_err_q <= 1'b0;
            ir_out_q    <= '0;
        end else begin
            instr_q     <= instr_d;
            shift_reg_q <= shift_reg_d;
            bypass_q    <= bypass_d;
            shift_cnt_q <= shift_cnt_d;
            wr_data_q   <= wr_data_d;
            wr_addr_q   <= wr_addr_d;
            wr_stb_q    <= wr_stb_d;
            shift_err_q <= shift_err_d;
            ir_out_q    <= ir_out_d;
        end
    end

    // tdo is taken straight from the register so the first captured bit
    // appears in the first Shift-DR cycle with no pipeline delay.
    assign tdo       = sel_valid ? shift_reg_q[0] : bypass_q;
    assign ir_out    = ir_out_q;
    assign wr_data   = wr_data_q;
    assign wr_addr   = wr_addr_q;
    assign wr_stb    = wr_stb_q;
    assign shift_err = shift_err_q;

endmodule

// File: tb/tb_vjtag_reg_bank.sv
module tb_vjtag_reg_bank;

    localparam int IRW = 2;
    localparam int DRW = 32;
    localparam int NR  = 3;

    logic                tck = 1'b0;
    logic                reset_n;
    logic                tdi;
    logic                tdo;
    logic [IRW-1:0]      ir_in;
    logic [IRW-1:0]      ir_out;
    logic                cdr, sdr, e1dr, pdr, e2dr, udr, cir, uir;
    logic [NR*DRW-1:0]   rd_data;
    logic [DRW-1:0]      wr_data;
    logic [IRW-1:0]      wr_addr;
    logic                wr_stb;
    logic                shift_err;

    vjtag_reg_bank #(.IR_WIDTH(IRW), .DR_WIDTH(DRW), .NUM_REGS(NR)) dut (
        .tck                (tck),
        .reset_n            (reset_n),
        .tdi                (tdi),
        .tdo                (tdo),
        .ir_in              (ir_in),
        .ir_out             (ir_out),
        .virtual_state_cdr  (cdr),
        .virtual_state_sdr  (sdr),
        .virtual_state_e1dr (e1dr),
        .virtual_state_pdr  (pdr),
        .virtual_state_e2dr (e2dr),
        .virtual_state_udr  (udr),
        .virtual_state_cir  (cir),
        .virtual_state_uir  (uir),
        .rd_data            (rd_data),
        .wr_data            (wr_data),
        .wr_addr            (wr_addr),
        .wr_stb             (wr_stb),
        .shift_err          (shift_err)
    );

    always #5 tck = ~tck;

    typedef struct packed {
        logic [IRW-1:0] addr;
        logic [DRW-1:0] data;
    } wr_t;

    typedef struct {
        int          ri;
        logic [31:0] rdv;
        logic [31:0] w;
        int          n1;
        int          np;
        int          ne2;
        int          n2;
        bit          exp_stb;
        bit          exp_err;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    wr_t  wr_q[$];
    logic tdo_q[$];
    wr_t  mon_w;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clr_states();
        cdr = 0; sdr = 0; e1dr = 0; pdr = 0; e2dr = 0; udr = 0; cir = 0; uir = 0;
        tdi = 0;
    endtask

    // Write-strobe scoreboard: every strobe must match the oldest expected write.
    always @(negedge tck) begin
        if (wr_stb === 1'b1) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL wr_stb unexpected actual=1 required=0 addr=%0h data=%0h", wr_addr, wr_data);
            end else begin
                mon_w = wr_q.pop_front();
                if (wr_addr !== mon_w.addr || wr_data !== mon_w.data) begin
                    errors++;
                    $display("FAIL wr_write actual=%0h/%0h required=%0h/%0h",
                             wr_addr, wr_data, mon_w.addr, mon_w.data);
                end
            end
        end
    end

    // Expected tdo is modelled as a FIFO: captured bits leave first, shifted-in
    // bits follow once the register depth has been consumed.
    task automatic shift_bits(input logic [31:0] w, input int first, input int n);
        for (int i = 0; i < n; i++) begin
            logic b;
            logic e;
            b = w[(first + i) % 32];
            clr_states();
            sdr = 1;
            tdi = b;
            if (tdo_q.size() > 0) begin
                e = tdo_q.pop_front();
                chk("tdo", 64'(tdo), 64'(e));
            end
            tdo_q.push_back(b);
            @(negedge tck);
        end
    endtask

    task automatic select_capture(input int ri, input logic [31:0] rdv);
        clr_states();
        ir_in = IRW'(ri);
        uir = 1;
        @(negedge tck);
        clr_states();
        cdr = 1;
        for (int k = 0; k < NR; k++) begin
            rd_data[k*DRW +: DRW] = (k == ri) ? rdv : (rdv ^ 32'h5A5A_5A5A ^ 32'(k));
        end
        tdo_q.delete();
        if (ri < NR) begin
            for (int b = 0; b < DRW; b++) tdo_q.push_back(rdv[b]);
        end else begin
            tdo_q.push_back(1'b0);
        end
        @(negedge tck);
    endtask

    task automatic run_scan(input int ri, input logic [31:0] rdv, input logic [31:0] w,
                            input int n1, input int np, input int ne2, input int n2);
        int exp_cnt;
        select_capture(ri, rdv);
        shift_bits(w, 0, n1);
        exp_cnt = (n1 > DRW + 1) ? DRW + 1 : n1;
        if (np > 0 || ne2 > 0) begin
            clr_states(); e1dr = 1;
            chk("cnt_e1dr", 64'(dut.shift_cnt_q), 64'(exp_cnt));
            @(negedge tck);
            for (int i = 0; i < np; i++) begin
                clr_states(); pdr = 1;
                chk("cnt_pdr", 64'(dut.shift_cnt_q), 64'(exp_cnt));
                @(negedge tck);
            end
            for (int i = 0; i < ne2; i++) begin
                clr_states(); e2dr = 1;
                chk("cnt_e2dr", 64'(dut.shift_cnt_q), 64'(exp_cnt));
                @(negedge tck);
            end
        end
        shift_bits(w, n1, n2);
        exp_cnt = (n1 + n2 > DRW + 1) ? DRW + 1 : n1 + n2;
        clr_states(); e1dr = 1;
        chk("cnt_final", 64'(dut.shift_cnt_q), 64'(exp_cnt));
        @(negedge tck);
    endtask

    task automatic do_udr(input int ri, input logic [31:0] w, input bit exp_stb);
        wr_t e;
        clr_states(); udr = 1;
        if (exp_stb) begin
            e.addr = IRW'(ri);
            e.data = w;
            wr_q.push_back(e);
        end
        @(negedge tck);
        clr_states();
        @(negedge tck);
        chk("wr_pending", 64'(wr_q.size()), 64'd0);
    endtask

    initial begin
        vec_t v;
        //          ri  rd value       tdi word       n1 np ne2 n2 stb err
        vecs[0] = '{1, 32'hA5A5_0F0F, 32'h1234_5678, 32, 0, 0,  0, 1'b1, 1'b0};
        vecs[1] = '{1, 32'hA5A5_0F0F, 32'h1234_5678, 31, 0, 0,  0, 1'b0, 1'b1};
        vecs[2] = '{0, 32'h0000_0000, 32'hFFFF_0000, 40, 0, 0,  0, 1'b0, 1'b1};
        vecs[3] = '{0, 32'h1357_9BDF, 32'h2468_ACE0,  0, 0, 0,  0, 1'b0, 1'b1};
        vecs[4] = '{3, 32'hFFFF_FFFF, 32'h0000_000D,  4, 0, 0,  0, 1'b0, 1'b0};
        vecs[5] = '{2, 32'h8000_0001, 32'h7FFF_FFFE, 33, 0, 0,  0, 1'b0, 1'b1};
        vecs[6] = '{0, 32'hFFFF_FFFF, 32'h0000_0001, 32, 0, 0,  0, 1'b1, 1'b0};
        vecs[7] = '{2, 32'hDEAD_BEEF, 32'hCAFE_F00D, 20, 5, 2, 12, 1'b1, 1'b0};

        clr_states();
        ir_in   = '0;
        rd_data = '0;
        reset_n = 0;
        repeat (2) @(negedge tck);
        reset_n = 1;
        chk("rst_tdo",       64'(tdo),            64'd0);
        chk("rst_ir_out",    64'(ir_out),         64'd0);
        chk("rst_wr_data",   64'(wr_data),        64'd0);
        chk("rst_wr_addr",   64'(wr_addr),        64'd0);
        chk("rst_wr_stb",    64'(wr_stb),         64'd0);
        chk("rst_shift_err", 64'(shift_err),      64'd0);
        chk("rst_instr",     64'(dut.instr_q),    64'd3);

        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            run_scan(v.ri, v.rdv, v.w, v.n1, v.np, v.ne2, v.n2);
            do_udr(v.ri, v.w, v.exp_stb);
            chk("vec_shift_err", 64'(shift_err), 64'(v.exp_err));
            clr_states(); cir = 1;
            @(negedge tck);
            chk("vec_ir_out",  64'(ir_out),    64'(v.exp_err));
            chk("vec_err_clr", 64'(shift_err), 64'd0);
            clr_states();
            @(negedge tck);
        end

        // Update-DR and Capture-IR together: the error set wins, ir_out shows the old flag.
        run_scan(0, 32'h0F0F_0F0F, 32'h3333_3333, 5, 0, 0, 0);
        do_udr(0, 32'h3333_3333, 1'b0);
        chk("seq_err_set", 64'(shift_err), 64'd1);
        run_scan(1, 32'h0F0F_0F0F, 32'h3333_3333, 7, 0, 0, 0);
        clr_states(); udr = 1; cir = 1;
        @(negedge tck);
        chk("udr_cir_ir_out", 64'(ir_out),    64'd1);
        chk("udr_cir_err",    64'(shift_err), 64'd1);
        clr_states(); cir = 1;
        @(negedge tck);
        chk("cir_ir_out", 64'(ir_out),    64'd1);
        chk("cir_err",    64'(shift_err), 64'd0);
        clr_states();
        @(negedge tck);

        // Reset arriving on bit 10 of a shift discards everything.
        run_scan(2, 32'h1111_2222, 32'h4444_5555, 3, 0, 0, 0);
        do_udr(2, 32'h4444_5555, 1'b0);
        chk("pre_rst_err", 64'(shift_err), 64'd1);
        select_capture(1, 32'hA5A5_0F0F);
        shift_bits(32'h1234_5678, 0, 10);
        clr_states(); sdr = 1; tdi = 1; reset_n = 0;
        @(negedge tck);
        reset_n = 1;
        tdo_q.delete();
        do_udr(1, 32'h0, 1'b0);
        chk("mid_rst_wr_data",   64'(wr_data),         64'd0);
        chk("mid_rst_wr_addr",   64'(wr_addr),         64'd0);
        chk("mid_rst_wr_stb",    64'(wr_stb),          64'd0);
        chk("mid_rst_shift_err", 64'(shift_err),       64'd0);
        chk("mid_rst_ir_out",    64'(ir_out),          64'd0);
        chk("mid_rst_tdo",       64'(tdo),             64'd0);
        chk("mid_rst_instr",     64'(dut.instr_q),     64'd3);
        chk("mid_rst_cnt",       64'(dut.shift_cnt_q), 64'd0);

        repeat (2) @(negedge tck);
        chk("final_pending", 64'(wr_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vjtag_reg_bank.md
Name: vjtag_reg_bank

Overview:
Parametrised virtual-JTAG data-register engine that sits behind the vJTAG virtual-instance primitive and runs entirely in the tck domain.
- Decodes a multi-bit virtual IR.
- Captures one of NUM_REGS parallel words into a DR_WIDTH shift register.
- Shifts TDI in and TDO out, LSB first.
- Issues a one-cycle write strobe on Update-DR when the shift length is exact.
- Reports sticky shift errors back through ir_out on Capture-IR.
- Supplies a 1-bit BYPASS register for unused instruction codes.

Parameters:
IR_WIDTH, 2, width of virtual IR (ir_in/ir_out); constraint NUM_REGS <= 2^IR_WIDTH - 1
DR_WIDTH, 32, width of each data register, >= 2
NUM_REGS, 3, number of addressable data registers, >= 1

Ports:
tck  input  1  vJTAG clock; all logic on rising edge
reset_n  input  1  synchronous active-low reset, sampled on tck
tdi  input  1  serial data from vJTAG
tdo  output  1  serial data to vJTAG
ir_in  input  IR_WIDTH  instruction value from vJTAG
ir_out  output  IR_WIDTH  status captured into virtual IR on Capture-IR
virtual_state_cdr  input  1  Capture-DR
virtual_state_sdr  input  1  Shift-DR
virtual_state_e1dr  input  1  Exit1-DR
virtual_state_pdr  input  1  Pause-DR
virtual_state_e2dr  input  1  Exit2-DR
virtual_state_udr  input  1  Update-DR
virtual_state_cir  input  1  Capture-IR
virtual_state_uir  input  1  Update-IR
rd_data  input  NUM_REGS*DR_WIDTH  parallel capture values; register k at bits [k*DR_WIDTH +: DR_WIDTH]
wr_data  output  DR_WIDTH  shifted-in word, valid with wr_stb
wr_addr  output  IR_WIDTH  register index, valid with wr_stb
wr_stb  output  1  one-tck write strobe
shift_err  output  1  sticky: last Update-DR discarded due to wrong shift length

Behaviour:
- Reset (reset_n=0 at tck edge) clears all state:
  - instr = all-ones (BYPASS); shift_reg = 0; bypass_reg = 0; shift_cnt = 0
  - wr_data = 0; wr_addr = 0; wr_stb = 0; shift_err = 0
  - ir_out = 0; tdo = 0
  - Reset overrides every state input in the same cycle.
- Instruction register:
  - On virtual_state_uir: instr <= ir_in.
  - Codes 0..NUM_REGS-1 select data register instr.
  - All other codes select BYPASS.
  - instr holds until the next uir or reset.
- Capture-DR (cdr=1):
  - Selected reg: shift_reg <= rd_data slice[instr]; shift_cnt <= 0.
  - BYPASS: bypass_reg <= 0; shift_cnt <= 0.
- Shift-DR (sdr=1), per cycle:
  - Selected reg: shift_reg <= {tdi, shift_reg[DR_WIDTH-1:1]}.
  - BYPASS: bypass_reg <= tdi.
  - shift_cnt increments, saturating at DR_WIDTH+1.
  - shift_cnt width = clog2(DR_WIDTH+2).
- tdo is combinational: shift_reg[0] when a data reg is selected, else bypass_reg.
  - First TDO bit after capture is rd_data bit 0 with zero latency.
- e1dr / pdr / e2dr: shift_reg, bypass_reg and shift_cnt hold.
  - Pause/resume continues the count, so a split shift totalling DR_WIDTH is valid.
- Update-DR (udr=1), data reg selected:
  - shift_cnt == DR_WIDTH: next cycle wr_stb=1 for exactly one tck; wr_data=shift_reg, wr_addr=instr.
  - Otherwise (short, long or zero shift): no strobe; shift_err <= 1.
  - BYPASS selected: no strobe, shift_err unchanged.
- wr_data / wr_addr hold their last values between strobes; wr_stb is 0 in all other cycles.
- Capture-IR (cir=1):
  - ir_out <= {(IR_WIDTH-1)'b0, shift_err}.
  - shift_err clears in the same cycle.
  - If udr and cir assert together (illegal in TAP, but defined here), the error set wins and ir_out still reports the pre-existing value.
- Simultaneous state inputs are never legal from the TAP. Priority for robustness: reset > uir > cdr > sdr > udr; cir is evaluated independently.
- Reset mid-shift: partial data is discarded, no strobe occurs, instr returns to BYPASS.
- Implementation size: roughly 150-250 lines.

Test Plan:
1. Reset, then uir with ir_in=1, cdr with rd_data reg1=0xA5A5_0F0F, 32 sdr cycles with tdi=bits of 0x1234_5678 LSB first, then udr.
   -> tdo stream = 0xA5A5_0F0F LSB first; one cycle later wr_stb=1, wr_addr=1, wr_data=0x1234_5678; shift_err=0.
2. Same sequence, but 31 sdr cycles before udr.
   -> wr_stb stays 0, shift_err=1; subsequent cir gives ir_out=2'b01 and shift_err returns to 0.
3. Shift 20 bits, 5 cycles pdr, 2 cycles e2dr, shift 12 bits, udr.
   -> wr_stb=1 with wr_data equal to the concatenated 32 bits; shift_cnt unchanged during pause.
4. uir with ir_in=3 (BYPASS), cdr, then sdr with tdi=1,0,1,1.
   -> tdo=0,1,0,1 (one-bit delay); udr produces no strobe and shift_err stays 0.
5. reset_n=0 asserted during bit 10 of a shift, then released, then udr.
   -> all outputs 0, instr=BYPASS, no strobe.
6. 40 sdr cycles with reg0 selected, then udr.
   -> shift_cnt saturates at 33, no strobe, shift_err=1.
